// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone B4 classic arbiter.
// Round-robin grant per CYC tenure, with a watchdog that turns a hung slave into ERR.
module wb_arbiter2 #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_CYC,
    input  logic             m0_STB,
    input  logic             m0_WE,
    input  logic [ADR_W-1:0] m0_ADR,
    input  logic [DAT_W-1:0] m0_DAT_O,
    input  logic [2:0]       m0_CTI,
    output logic [DAT_W-1:0] m0_DAT_I,
    output logic             m0_ACK,
    output logic             m0_ERR,
    output logic             m0_RTY,

    input  logic             m1_CYC,
    input  logic             m1_STB,
    input  logic             m1_WE,
    input  logic [ADR_W-1:0] m1_ADR,
    input  logic [DAT_W-1:0] m1_DAT_O,
    input  logic [2:0]       m1_CTI,
    output logic [DAT_W-1:0] m1_DAT_I,
    output logic             m1_ACK,
    output logic             m1_ERR,
    output logic             m1_RTY,

    output logic             s_CYC,
    output logic             s_STB,
    output logic             s_WE,
    output logic [ADR_W-1:0] s_ADR,
    output logic [DAT_W-1:0] s_DAT_O,
    output logic [2:0]       s_CTI,
    input  logic [DAT_W-1:0] s_DAT_I,
    input  logic             s_ACK,
    input  logic             s_ERR,
    input  logic             s_RTY
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t          state;
    logic            last;
    logic [CW-1:0]   wdog;
    logic            own0;
    logic            own1;
    logic            hold;
    logic            s_term;
    logic            stall;
    logic            timeout;

    assign own0    = (state == GNT0);
    assign own1    = (state == GNT1);
    assign hold    = (own0 & m0_CYC) | (own1 & m1_CYC);
    assign s_term  = s_ACK | s_ERR | s_RTY;
    // Stall is taken from the owner's STB directly so the timeout ERR has no path through s_STB.
    assign stall   = ((own0 & m0_STB) | (own1 & m1_STB)) & ~s_term;
    assign timeout = (TIMEOUT > 0) && stall && (wdog == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            wdog <= ((TIMEOUT > 0) && stall && hold && !timeout) ? wdog + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (m0_CYC && (!m1_CYC || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_CYC) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (timeout) begin
                        state <= ABORT;
                    end else if (!m0_CYC) begin
                        if (m1_CYC) begin
                            state <= GNT1;
                            last  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (timeout) begin
                        state <= ABORT;
                    end else if (!m1_CYC) begin
                        if (m0_CYC) begin
                            state <= GNT0;
                            last  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ABORT: begin
                    // The aborted owner is still recorded in last; wait for it to let go.
                    if (!last && !m0_CYC) begin
                        if (m1_CYC) begin
                            state <= GNT1;
                            last  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (last && !m1_CYC) begin
                        if (m0_CYC) begin
                            state <= GNT0;
                            last  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_CYC    = 1'b0;
        s_STB    = 1'b0;
        s_WE     = 1'b0;
        s_ADR    = '0;
        s_DAT_O  = '0;
        s_CTI    = 3'b000;
        m0_DAT_I = '0;
        m0_ACK   = 1'b0;
        m0_ERR   = 1'b0;
        m0_RTY   = 1'b0;
        m1_DAT_I = '0;
        m1_ACK   = 1'b0;
        m1_ERR   = 1'b0;
        m1_RTY   = 1'b0;
        if (own0) begin
            s_CYC    = m0_CYC;
            s_STB    = m0_STB;
            s_WE     = m0_WE;
            s_ADR    = m0_ADR;
            s_DAT_O  = m0_DAT_O;
            s_CTI    = m0_CTI;
            m0_DAT_I = s_DAT_I;
            m0_ACK   = s_ACK & m0_STB;
            m0_ERR   = (s_ERR & m0_STB) | timeout;
            m0_RTY   = s_RTY & m0_STB;
        end else if (own1) begin
            s_CYC    = m1_CYC;
            s_STB    = m1_STB;
            s_WE     = m1_WE;
            s_ADR    = m1_ADR;
            s_DAT_O  = m1_DAT_O;
            s_CTI    = m1_CTI;
            m1_DAT_I = s_DAT_I;
            m1_ACK   = s_ACK & m1_STB;
            m1_ERR   = (s_ERR & m1_STB) | timeout;
            m1_RTY   = s_RTY & m1_STB;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: masters push expected terminations, a monitor pops and compares.
module tb_wb_arbiter2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mCyc[2];
    logic        mStb[2];
    logic        mWe[2];
    logic [31:0] mAdr[2];
    logic [31:0] mDatO[2];
    logic [2:0]  mCti[2];
    logic [31:0] mDatI[2];
    logic [1:0]  mAck;
    logic [1:0]  mErr;
    logic [1:0]  mRty;
    logic        sCyc, sStb, sWe;
    logic [31:0] sAdr, sDatO;
    logic [2:0]  sCti;
    logic [31:0] sDatI;
    logic        sAck, sErr, sRty;

    typedef struct {
        logic        err;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   logQ[$];
    int   checks = 0;
    int   errors = 0;
    int   ackDelay = 1;
    bit   mute = 1'b0;
    bit   m1Done;
    int   lockHits;
    int   errCycles;
    int   errAt;

    wb_arbiter2 #(.ADR_W(32), .DAT_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_CYC(mCyc[0]), .m0_STB(mStb[0]), .m0_WE(mWe[0]), .m0_ADR(mAdr[0]),
        .m0_DAT_O(mDatO[0]), .m0_CTI(mCti[0]), .m0_DAT_I(mDatI[0]),
        .m0_ACK(mAck[0]), .m0_ERR(mErr[0]), .m0_RTY(mRty[0]),
        .m1_CYC(mCyc[1]), .m1_STB(mStb[1]), .m1_WE(mWe[1]), .m1_ADR(mAdr[1]),
        .m1_DAT_O(mDatO[1]), .m1_CTI(mCti[1]), .m1_DAT_I(mDatI[1]),
        .m1_ACK(mAck[1]), .m1_ERR(mErr[1]), .m1_RTY(mRty[1]),
        .s_CYC(sCyc), .s_STB(sStb), .s_WE(sWe), .s_ADR(sAdr), .s_DAT_O(sDatO),
        .s_CTI(sCti), .s_DAT_I(sDatI), .s_ACK(sAck), .s_ERR(sErr), .s_RTY(sRty)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Slave model: ACKs after ackDelay wait states unless muted; read data is address-derived.
    initial begin
        int cnt;
        cnt = 0;
        sAck = 1'b0;
        sErr = 1'b0;
        sRty = 1'b0;
        sDatI = '0;
        forever begin
            @(posedge clk);
            #2;
            sDatI = sAdr ^ 32'hDEAD_0000;
            if (sAck) begin
                sAck = 1'b0;
                cnt = 0;
            end else if (sCyc && sStb && !mute) begin
                if (cnt >= ackDelay) begin
                    sAck = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic handleTerm(input int m);
        exp_t e;
        logQ.push_back(m);
        if ((m == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected term m%0d: got termination, required none", m);
        end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput("term kind err", {31'b0, mErr[m]}, {31'b0, e.err});
            checkOutput("owner s_ADR", sAdr, e.adr);
            if (e.we)
                checkOutput("write data", sDatO, e.dat);
            else if (!e.err)
                checkOutput("read data", mDatI[m], e.dat);
            checkOutput("non-owner DAT_I", mDatI[1-m], 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                if (mAck[m] || mErr[m])
                    handleTerm(m);
            end
        end
    end

    // One single classic transfer from master m; the expected termination is queued at issue.
    task automatic applyStimulus(input int m, input logic [31:0] adr, input logic we,
                                 input logic [31:0] dat, input bit holdCyc);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        mCyc[m]  = 1'b1;
        mStb[m]  = 1'b1;
        mWe[m]   = we;
        mAdr[m]  = adr;
        mDatO[m] = we ? dat : 32'h0;
        mCti[m]  = 3'b111;
        e.err = 1'b0;
        e.we  = we;
        e.adr = adr;
        e.dat = we ? dat : (adr ^ 32'hDEAD_0000);
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mAck[m] || mErr[m]) && n < 100);
        checkOutput("transfer completes", {31'b0, mAck[m] | mErr[m]}, 32'h1);
        @(posedge clk);
        #1;
        mStb[m] = 1'b0;
        if (!holdCyc) mCyc[m] = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mCyc[m] = 1'b0; mStb[m] = 1'b0; mWe[m] = 1'b0;
            mAdr[m] = '0; mDatO[m] = '0; mCti[m] = 3'b000;
        end
        mute = 1'b0;
        ackDelay = 1;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        logQ.delete();
    endtask

    task automatic endTest();
        checkOutput("m0 queue drained", q0.size(), 32'd0);
        checkOutput("m1 queue drained", q1.size(), 32'd0);
    endtask

    initial begin
        doReset();
        checkOutput("reset s_CYC", {31'b0, sCyc}, 32'h0);
        checkOutput("reset s_STB", {31'b0, sStb}, 32'h0);
        checkOutput("reset s_ADR", sAdr, 32'h0);
        checkOutput("reset m ACK/ERR", {28'b0, mAck, mErr}, 32'h0);

        $display("[TB] single master write");
        ackDelay = 2;
        fork
            applyStimulus(0, 32'h10, 1'b1, 32'h10, 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                checkOutput("grant latency pre-edge s_CYC", {31'b0, sCyc}, 32'h0);
                @(negedge clk);
                checkOutput("grant s_CYC", {31'b0, sCyc}, 32'h1);
                checkOutput("grant s_ADR", sAdr, 32'h10);
                checkOutput("grant s_WE", {31'b0, sWe}, 32'h1);
                checkOutput("grant s_DAT_O", sDatO, 32'h10);
                checkOutput("grant s_CTI", {29'b0, sCti}, 32'h7);
            end
        join
        repeat (2) @(negedge clk);
        checkOutput("single term count", logQ.size(), 32'd1);
        endTest();

        $display("[TB] simultaneous request and handover");
        doReset();
        fork
            applyStimulus(0, 32'h14, 1'b0, 32'h0, 1'b0);
            applyStimulus(1, 32'h114, 1'b0, 32'h0, 1'b0);
            begin
                int n;
                @(posedge clk);
                @(negedge clk);
                @(negedge clk);
                checkOutput("tie winner s_ADR", sAdr, 32'h14);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (mCyc[0] && n < 100);
                @(negedge clk);
                checkOutput("handover s_CYC", {31'b0, sCyc}, 32'h1);
                checkOutput("handover s_ADR", sAdr, 32'h114);
            end
        join
        checkOutput("tie order len", logQ.size(), 32'd2);
        for (int i = 0; i < logQ.size(); i++)
            checkOutput("tie order", logQ[i], i);
        endTest();

        $display("[TB] back-to-back alternation");
        doReset();
        fork
            for (int i = 0; i < 4; i++) applyStimulus(0, 32'h40 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 4; i++) applyStimulus(1, 32'h140 + 32'(i * 4), 1'b1, 32'h5000 + 32'(i), 1'b0);
        join
        checkOutput("alternation len", logQ.size(), 32'd8);
        for (int i = 0; i < logQ.size(); i++)
            checkOutput("alternation owner", logQ[i], i % 2);
        endTest();

        $display("[TB] bus lock across STB phases");
        doReset();
        m1Done = 1'b0;
        lockHits = 0;
        fork
            begin
                applyStimulus(1, 32'h180, 1'b1, 32'hA1, 1'b1);
                applyStimulus(1, 32'h184, 1'b1, 32'hA2, 1'b1);
                applyStimulus(1, 32'h188, 1'b1, 32'hA3, 1'b0);
                m1Done = 1'b1;
            end
            begin
                repeat (2) @(posedge clk);
                applyStimulus(0, 32'h24, 1'b1, 32'hB1, 1'b0);
            end
            begin
                int n;
                n = 0;
                while (!m1Done && n < 200) begin
                    @(negedge clk);
                    if (!m1Done && sCyc && sAdr == 32'h24) lockHits++;
                    n++;
                end
            end
        join
        checkOutput("lock no m0 address", lockHits, 32'd0);
        checkOutput("lock order len", logQ.size(), 32'd4);
        for (int i = 0; i < logQ.size(); i++)
            checkOutput("lock order", logQ[i], (i < 3) ? 1 : 0);
        endTest();

        $display("[TB] watchdog timeout");
        doReset();
        mute = 1'b1;
        @(posedge clk);
        #1;
        mCyc[0] = 1'b1; mStb[0] = 1'b1; mWe[0] = 1'b0; mAdr[0] = 32'h30;
        q0.push_back('{err: 1'b1, we: 1'b0, adr: 32'h30, dat: 32'h0});
        errCycles = 0;
        errAt = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mErr[0]) begin
                errCycles++;
                errAt = k;
            end
            if (k == 9) begin
                checkOutput("abort s_CYC", {31'b0, sCyc}, 32'h0);
                checkOutput("abort s_STB", {31'b0, sStb}, 32'h0);
            end
        end
        checkOutput("timeout ERR cycles", errCycles, 32'd1);
        checkOutput("timeout ERR cycle index", errAt, TO);
        mute = 1'b0;
        fork
            applyStimulus(1, 32'h130, 1'b1, 32'h55, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                mCyc[0] = 1'b0;
                mStb[0] = 1'b0;
            end
        join
        checkOutput("post-abort len", logQ.size(), 32'd2);
        if (logQ.size() == 2) checkOutput("post-abort owner", logQ[1], 32'd1);
        endTest();

        $display("[TB] asynchronous reset mid-transfer");
        doReset();
        mute = 1'b1;
        @(posedge clk);
        #1;
        mCyc[0] = 1'b1; mStb[0] = 1'b1; mWe[0] = 1'b1; mAdr[0] = 32'h60; mDatO[0] = 32'h66;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre-reset s_CYC", {31'b0, sCyc}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset s_CYC", {31'b0, sCyc}, 32'h0);
        checkOutput("async reset s_STB", {31'b0, sStb}, 32'h0);
        mCyc[0] = 1'b0;
        mStb[0] = 1'b0;
        mute = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle after reset", {31'b0, sCyc}, 32'h0);
        fork
            applyStimulus(0, 32'h70, 1'b0, 32'h0, 1'b0);
            applyStimulus(1, 32'h170, 1'b0, 32'h0, 1'b0);
        join
        checkOutput("post-reset tie len", logQ.size(), 32'd2);
        for (int i = 0; i < logQ.size(); i++)
            checkOutput("post-reset tie order", logQ[i], i);
        endTest();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone B4 classic-cycle arbiter with round-robin fairness and a bus-timeout watchdog. It sits between two bus masters, such as the CPU fetch/data ports or a test master, and a single shared slave port such as memory or the peripheral interconnect. It grants the slave to one master per CYC tenure, routes termination signals only to the owner, and turns a hung slave into an ERR termination.

## Interface
Parameters:
- ADR_W, 32, address width
- DAT_W, 32, data width
- TIMEOUT, 256, cycles with STB high and no termination before abort; 0 disables the watchdog

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- m0_CYC, m0_STB, m0_WE  in  1 each  master 0 cycle, strobe and write enable
- m0_ADR  in  ADR_W  master 0 address
- m0_DAT_O  in  DAT_W  master 0 write data
- m0_CTI  in  3  master 0 cycle type
- m0_DAT_I  out  DAT_W  read data to master 0
- m0_ACK, m0_ERR, m0_RTY  out  1 each  terminations to master 0
- m1_*  same set as m0_*  master 1
- s_CYC, s_STB, s_WE  out  1 each  slave cycle, strobe and write enable
- s_ADR  out  ADR_W  slave address
- s_DAT_O  out  DAT_W  write data to slave
- s_CTI  out  3  slave cycle type
- s_DAT_I  in  DAT_W  slave read data
- s_ACK, s_ERR, s_RTY  in  1 each  slave terminations

## Operation
- The state register has four states:
  - IDLE: no master owns the slave.
  - GNT0: master 0 owns the slave.
  - GNT1: master 1 owns the slave.
  - ABORT: the owner's transfer timed out.
- A 1-bit `last` register records the most recently granted master.
- IDLE transitions:
  - Only one mX_CYC high: go to GNTX.
  - Both high: grant the master ≠ last.
  - Neither high: stay in IDLE.
- GNTX transitions:
  - mX_CYC high: hold GNTX. The owner keeps the bus across multiple STB phases while CYC is held (bus lock).
  - mX_CYC low and the other CYC high: go directly to the other GNT state.
  - Both CYC low: go to IDLE.
  - `last` updates to X on every entry into GNTX.
- Slave-side outputs are a combinational mux driven by the registered grant.
  - In GNTX: s_* = mX_* (CYC, STB, WE, ADR, DAT_O, CTI).
  - In IDLE or ABORT: all s_* = 0.
- Master-side outputs:
  - mX_DAT_I = s_DAT_I when X is granted, else 0.
  - mX_ACK/ERR/RTY = s_ACK/ERR/RTY & mX_STB, gated to the granted master only.
  - The non-owner always sees 0 on ACK/ERR/RTY.
- Watchdog counter:
  - Width is $clog2(TIMEOUT+1).
  - Increments each cycle in GNTX with s_STB=1 and no s_ACK/ERR/RTY.
  - Clears on any termination, when STB=0, or on a state change.
- Timeout action (counter reaches TIMEOUT−1 while still unterminated):
  - In that cycle the arbiter drives the owner's mX_ERR=1 itself. This is combinational, for exactly 1 cycle.
  - The state goes to ABORT.
- ABORT:
  - Slave side is deasserted.
  - Stay in ABORT until the owner drops CYC, then follow the GNTX release rules.
  - A slave ACK arriving during ABORT is discarded.
- Reset (rst=0), asynchronous:
  - state=IDLE, last=1 (master 0 wins the first tie), counter=0.
  - All outputs are 0.
  - Reset asserted mid-transfer drops s_CYC/s_STB immediately, without waiting for a clock.

## Timing
- Grant latency: mX_CYC rising → s_CYC high on the next clk edge (1 cycle). Masters must hold STB/ADR until ACK, as Wishbone classic requires.
- Data path and terminations are combinational. There is zero added latency from s_ACK to mX_ACK.
- Handover: owner drops CYC at edge n while the other master is requesting → the other master's s_CYC appears at edge n+1. There are no idle cycles between tenures.
- Simultaneous requests on the same edge: round-robin by `last`. Two masters hammering back-to-back alternate grants.
- A new request during the owner's tenure waits. It never pre-empts.
- Timeout ERR is asserted TIMEOUT cycles after the first unterminated STB cycle.
- TIMEOUT=0: the counter is tied to 0 and ABORT is unreachable.

## Test plan
- Reset, then m0 only: m0 writes ADR=0x10 with data 0x10; slave ACKs after 2 cycles. Required: s_CYC high 1 cycle after m0_CYC, s_ADR=0x10, m0_ACK pulses, m1_ACK stays 0.
- Both masters raise CYC on the same edge after reset. Required: m0 granted first; after m0 drops CYC, m1 is granted on the next edge with no IDLE cycle.
- Both masters issue continuous single transfers for 8 tenures. Required: grants alternate 0,1,0,1…; each master completes 4 transfers.
- m1 holds CYC across 3 STB phases while m0 requests. Required: m0 is blocked until m1_CYC falls; s_ADR never shows m0_ADR during m1's tenure.
- TIMEOUT=8, slave never ACKs a read from m0. Required: m0_ERR=1 for exactly 1 cycle, 8 cycles after STB; s_CYC=0 from the next edge; after m0 drops CYC, m1 can be granted.
- Assert rst low mid-transfer, asynchronously to clk. Required: s_CYC/s_STB drop immediately; after release, state is IDLE and m0 wins a tie.
